// File: rtl/cla_nibble_sequencer_if.sv
// Operand/result bundle for the nibble-serial adder: request side, abort and result handshake.
// The consumer side (master) drives operands and acknowledges; the adder (slave) reports state and result.
interface cla_nibble_sequencer_if;
    logic        start;
    logic        op_sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        abort;
    logic        result_ack;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    modport master (
        output start, op_sub, a, b, cin, abort, result_ack,
        input  ready, busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, op_sub, a, b, cin, abort, result_ack,
        output ready, busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/cla_nibble_sequencer.sv
// 16-bit add/subtract using one 4-bit carry-lookahead adder, one nibble per cycle.
// Latency: done rises 4 edges after start is accepted; result held until result_ack.
// Backpressure: start only accepted while ready; abort cancels a run without touching the result.
module cla_nibble_sequencer (
    input  logic                     clk,
    input  logic                     rst_n,
    cla_nibble_sequencer_if.slave    bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state;
    logic [1:0]  nibble_cnt;
    logic        carry_reg;
    logic [15:0] a_reg;
    logic [15:0] beff_reg;
    logic [15:0] acc;
    logic [15:0] sum_q;
    logic        cout_q;
    logic        ovf_q;

    logic [3:0]  na, nb, ng, np, nsum;
    logic [4:0]  c;
    logic [15:0] acc_next;

    // Single shared 4-bit lookahead adder, operand nibble selected by nibble_cnt.
    always_comb begin
        na   = a_reg[{nibble_cnt, 2'b00} +: 4];
        nb   = beff_reg[{nibble_cnt, 2'b00} +: 4];
        ng   = na & nb;
        np   = na ^ nb;
        c[0] = carry_reg;
        c[1] = ng[0] | (np[0] & c[0]);
        c[2] = ng[1] | (np[1] & ng[0]) | (np[1] & np[0] & c[0]);
        c[3] = ng[2] | (np[2] & ng[1]) | (np[2] & np[1] & ng[0])
             | (np[2] & np[1] & np[0] & c[0]);
        c[4] = ng[3] | (np[3] & ng[2]) | (np[3] & np[2] & ng[1])
             | (np[3] & np[2] & np[1] & ng[0])
             | (np[3] & np[2] & np[1] & np[0] & c[0]);
        nsum = np ^ c[3:0];
        acc_next = acc;
        acc_next[{nibble_cnt, 2'b00} +: 4] = nsum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            nibble_cnt <= 2'd0;
            carry_reg  <= 1'b0;
            a_reg      <= 16'h0000;
            beff_reg   <= 16'h0000;
            acc        <= 16'h0000;
            sum_q      <= 16'h0000;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_reg      <= bus.a;
                        // Subtract folds into add: A + ~B + 1.
                        beff_reg   <= bus.op_sub ? ~bus.b : bus.b;
                        carry_reg  <= bus.op_sub ? 1'b1 : bus.cin;
                        nibble_cnt <= 2'd0;
                        acc        <= 16'h0000;
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.abort) begin
                        acc        <= 16'h0000;
                        nibble_cnt <= 2'd0;
                        state      <= ST_IDLE;
                    end else begin
                        acc        <= acc_next;
                        carry_reg  <= c[4];
                        nibble_cnt <= nibble_cnt + 2'd1;
                        if (nibble_cnt == 2'd3) begin
                            sum_q  <= acc_next;
                            cout_q <= c[4];
                            ovf_q  <= (a_reg[15] == beff_reg[15]) & (nsum[3] != a_reg[15]);
                            state  <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.result_ack) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ready = (state == ST_IDLE);
    assign bus.busy  = (state == ST_RUN);
    assign bus.done  = (state == ST_DONE);
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Directed and random checks of the nibble-serial adder against a plain-arithmetic model.
module tb_cla_nibble_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    cla_nibble_sequencer_if bus();

    cla_nibble_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: whole-word arithmetic, signed range test for overflow.
    task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic mc,
                         input logic ms, output logic [15:0] s, output logic co, output logic ov);
        logic [16:0] w;
        int sa, sb, r;
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (ms) begin
            w  = 17'(ma) - 17'(mb);
            co = (ma >= mb);
            r  = sa - sb;
        end else begin
            w  = 17'(ma) + 17'(mb) + 17'(mc);
            co = w[16];
            r  = sa + sb + int'(mc);
        end
        s  = w[15:0];
        ov = (r > 32767) || (r < -32768);
    endtask

    task automatic ack_result(input string tag);
        bus.result_ack = 1'b1;
        step();
        bus.result_ack = 1'b0;
        chk({tag, "_ready_after_ack"}, 32'(bus.ready), 32'd1);
    endtask

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tcin,
                          input logic tsub, input logic [15:0] es, input logic ec,
                          input logic eo, input string tag);
        logic [15:0] prev;
        int edges, busyc;
        prev = bus.sum;
        bus.a = ta; bus.b = tb_; bus.cin = tcin; bus.op_sub = tsub; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        edges = 20; busyc = 0;
        for (int i = 1; i <= 20; i++) begin
            if (bus.busy) busyc++;
            chk({tag, "_sum_hold"}, 32'(bus.sum), 32'(prev));
            step();
            if (bus.done) begin edges = i; break; end
        end
        chk({tag, "_latency"}, 32'(edges), 32'd4);
        chk({tag, "_busy_cycles"}, 32'(busyc), 32'd4);
        chk({tag, "_sum"}, 32'(bus.sum), 32'(es));
        chk({tag, "_cout"}, 32'(bus.cout), 32'(ec));
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
        ack_result(tag);
    endtask

    initial begin
        logic [15:0] ra, rb, es;
        logic rc, rs, ec, eo;
        int n;
        bus.start = 0; bus.op_sub = 0; bus.a = 0; bus.b = 0; bus.cin = 0;
        bus.abort = 0; bus.result_ack = 0;
        #2;
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        #10 rst_n = 1'b1;
        step();
        step();
        chk("idle_hold_ready", 32'(bus.ready), 32'd1);

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "add_5555");
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_carry_all");
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");

        // Start held high through RUN and DONE, abort in DONE, ack withheld.
        bus.a = 16'h0001; bus.b = 16'h0002; bus.cin = 0; bus.op_sub = 0; bus.start = 1;
        step();
        bus.a = 16'hAAAA; bus.b = 16'h5555; bus.op_sub = 1;
        n = 0;
        while (!bus.done && n < 20) begin step(); n++; end
        chk("ign_start_latency", 32'(n), 32'd4);
        chk("ign_start_sum", 32'(bus.sum), 32'h0003);
        bus.abort = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_done", 32'(bus.done), 32'd1);
            chk("hold_sum", 32'(bus.sum), 32'h0003);
        end
        bus.start = 0; bus.abort = 0;
        ack_result("held");
        step();
        chk("no_queued_ready", 32'(bus.ready), 32'd1);
        chk("no_queued_busy", 32'(bus.busy), 32'd0);

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "pre_abort");
        // Abort on the second RUN cycle.
        bus.a = 16'hFFFF; bus.b = 16'h0001; bus.cin = 0; bus.op_sub = 0; bus.start = 1;
        step();
        bus.start = 0;
        step();
        bus.abort = 1;
        step();
        bus.abort = 0;
        chk("abort_ready", 32'(bus.ready), 32'd1);
        chk("abort_sum", 32'(bus.sum), 32'h5555);
        n = 0;
        for (int i = 0; i < 6; i++) begin step(); if (bus.done) n++; end
        chk("abort_no_done", 32'(n), 32'd0);

        // Abort coinciding with the last nibble.
        bus.a = 16'h0F0F; bus.b = 16'h0101; bus.start = 1;
        step();
        bus.start = 0;
        step(); step(); step();
        bus.abort = 1;
        step();
        bus.abort = 0;
        chk("abort_last_ready", 32'(bus.ready), 32'd1);
        chk("abort_last_done", 32'(bus.done), 32'd0);
        chk("abort_last_sum", 32'(bus.sum), 32'h5555);

        // Asynchronous reset mid-RUN.
        bus.a = 16'h1111; bus.b = 16'h2222; bus.start = 1;
        step();
        bus.start = 0;
        step();
        #1 rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(bus.ready), 32'd1);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_sum", 32'(bus.sum), 32'd0);
        chk("arst_cout_ovf", 32'({bus.cout, bus.ovf}), 32'd0);
        #1 rst_n = 1'b1;
        step();
        run_op(16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0, "after_rst");

        for (int i = 0; i < 25; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            model(ra, rb, rc, rs, es, ec, eo);
            run_op(ra, rb, rc, rs, es, ec, eo, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
